// File: rtl/weights_fetch_ctrl_pkg.sv
// Shared types and constants for the weight-fetch controller.
package weights_fetch_ctrl_pkg;

    localparam int unsigned AW_DEF     = 8;
    localparam int unsigned FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/weights_fetch_ctrl_if.sv
// Burst request, weight ROM port and weight stream of the fetch controller.
interface weights_fetch_ctrl_if
    import weights_fetch_ctrl_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned AW = AW_DEF
);
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic [AW-1:0] rom_addr;
    logic [N-1:0]  rom_data;
    logic [N-1:0]  w_data;
    logic          w_valid;
    logic          w_ready;
    logic          w_last;
    logic          busy;
    logic          done;

    modport master (
        input  start, base_addr, count, rom_data, w_ready,
        output rom_addr, w_data, w_valid, w_last, busy, done
    );

    modport slave (
        output start, base_addr, count, rom_data, w_ready,
        input  rom_addr, w_data, w_valid, w_last, busy, done
    );
endinterface

// File: rtl/weights_fifo2.sv
// Two-entry head/tail FIFO; the head register drives the output directly.
module weights_fifo2 #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout,
    output logic         valid,
    output logic [1:0]   level_c
);
    logic [N-1:0] head_q;
    logic [N-1:0] tail_q;
    logic         head_v;
    logic         tail_v;
    logic         pop_ok;

    assign pop_ok  = pop & head_v;
    assign dout    = head_q;
    assign valid   = head_v;
    assign level_c = 2'(head_v) + 2'(tail_v);

    // Tail is only ever occupied behind a valid head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            head_v <= 1'b0;
            tail_v <= 1'b0;
        end else if (pop_ok) begin
            if (tail_v) begin
                head_q <= tail_q;
                if (push) tail_q <= din;
                else      tail_v <= 1'b0;
            end else if (push) begin
                head_q <= din;
            end else begin
                head_v <= 1'b0;
            end
        end else if (push) begin
            if (!head_v) begin
                head_q <= din;
                head_v <= 1'b1;
            end else if (!tail_v) begin
                tail_q <= din;
                tail_v <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/weights_fetch_ctrl.sv
// Streams a burst of weight words from a one-cycle-latency ROM to the neuron
// datapath, with read issue throttled so the 2-entry output FIFO never overflows.
module weights_fetch_ctrl
    import weights_fetch_ctrl_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned Q  = 7,
    parameter int unsigned AW = AW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    weights_fetch_ctrl_if.master bus
);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned FW = N + 1;

    // Q only describes the fixed-point format of the words passed through.
    if (Q >= N) begin : g_bad_q
        $error("Q must be smaller than N");
    end

    fetch_state_e  state_q;
    fetch_state_e  state_d;
    logic [AW-1:0] addr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] issued_q;
    logic [CW-1:0] pushed_q;
    logic          inflight_q;
    logic          busy_q;
    logic          done_q;
    logic          busy_d;
    logic          done_d;

    logic          load_c;
    logic          issue_c;
    logic          pop_c;
    logic          push_c;
    logic          push_last_c;
    logic          last_xfer_c;
    logic [2:0]    occ_c;
    logic [1:0]    level_c;
    logic [FW-1:0] fifo_dout;
    logic          fifo_valid;

    // Words held or in flight, counting the slot freed by this cycle's pop.
    assign pop_c       = fifo_valid & bus.w_ready;
    assign push_c      = inflight_q;
    assign occ_c       = 3'(level_c) + 3'(inflight_q) - 3'(pop_c);
    assign issue_c     = (state_q == ST_FETCH) && (occ_c < 3'(FIFO_DEPTH));
    assign load_c      = (state_q == ST_IDLE) && bus.start && (bus.count != '0);
    assign push_last_c = (pushed_q == CW'(count_q - 1'b1));
    assign last_xfer_c = pop_c & fifo_dout[N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = (bus.count == '0) ? ST_DONE : ST_FETCH;
            end
            ST_FETCH: begin
                if (issue_c && (issued_q == CW'(count_q - 1'b1))) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (last_xfer_c) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        if (state_d != ST_IDLE) busy_d = 1'b1;
        if (state_d == ST_DONE) done_d = 1'b1;
    end

    // Address, burst counters and read-in-flight tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            count_q    <= '0;
            issued_q   <= '0;
            pushed_q   <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            done_q     <= done_d;
            inflight_q <= issue_c;
            if (load_c) begin
                addr_q   <= bus.base_addr;
                count_q  <= bus.count;
                issued_q <= '0;
                pushed_q <= '0;
            end else begin
                if (issue_c) begin
                    addr_q   <= AW'(addr_q + 1'b1);
                    issued_q <= CW'(issued_q + 1'b1);
                end
                if (push_c) pushed_q <= CW'(pushed_q + 1'b1);
            end
        end
    end

    weights_fifo2 #(.N(FW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_c),
        .pop     (pop_c),
        .din     ({push_last_c, bus.rom_data}),
        .dout    (fifo_dout),
        .valid   (fifo_valid),
        .level_c (level_c)
    );

    assign bus.rom_addr = addr_q;
    assign bus.w_data   = fifo_dout[N-1:0];
    assign bus.w_valid  = fifo_valid;
    assign bus.w_last   = fifo_valid & fifo_dout[N];
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule
